// File: rtl/sync_down_timer.sv
// Loadable synchronous down-counter/timer.
// Loads a start value, decrements on enabled clocks and emits a one-cycle
// terminal-count pulse when the count steps from 1 to 0 (or on a load of 0).
// One-shot mode parks in DONE after the pulse; auto-reload mode wraps back
// to the reload value on the next enabled cycle, giving a period of
// reload_reg+1 enabled cycles.
//
// Handshake: none. load and en are level-sampled on every rising edge.
// load has priority over en. rst (synchronous, active-high) has priority
// over everything.
module sync_down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] reload_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;

    // Next-state, next-count and terminal-count decision for this edge.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload_reg;
        tc_nxt     = 1'b0;

        if (load) begin
            // A load restarts from any state; no pulse for an aborted run.
            count_nxt  = load_val;
            reload_nxt = load_val;
            if (load_val == ZERO) begin
                // Zero load finishes immediately, even in auto-reload mode,
                // so a zero period can never loop.
                state_nxt = DONE;
                tc_nxt    = 1'b1;
            end else begin
                state_nxt = RUN;
            end
        end else begin
            case (state)
                RUN: begin
                    if (en) begin
                        if (count == ZERO) begin
                            // Only reachable in auto-reload: wrap without a pulse.
                            count_nxt = reload_reg;
                        end else if (count == ONE) begin
                            count_nxt = ZERO;
                            tc_nxt    = 1'b1;
                            if (!auto_reload) begin
                                state_nxt = DONE;
                            end
                        end else begin
                            count_nxt = count - ONE;
                        end
                    end
                end
                IDLE: state_nxt = IDLE;
                DONE: state_nxt = DONE;
                default: begin
                    // Unused encoding: fall back to a safe idle state.
                    state_nxt = IDLE;
                    count_nxt = ZERO;
                end
            endcase
        end
    end

    // Register state, count, reload value and the derived status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= ZERO;
            reload_reg <= ZERO;
            tc         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            reload_reg <= reload_nxt;
            tc         <= tc_nxt;
            busy       <= (state_nxt == RUN);
            done       <= (state_nxt == DONE);
        end
    end

endmodule
